runway_scheduler: RTL and testbench

- Sequences runway usage for the BobATC tower: holds pending landing and takeoff requests decoded by the UART command path and grants them onto two runways.
- Landings have priority over takeoffs. Manual runway closures and the emergency override are honoured.
- Issued grants go back to the UART transmit path over a valid/ready handshake.
- Drives the chip-level runway_active and emergency indicators.

---
 rtl/runway_scheduler.sv | 149 ++++++++++++++
 tb/tb_runway_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/runway_scheduler.sv
// Runway scheduler: queues landing/takeoff requests and grants them onto two
// runways. Landings beat takeoffs, closed runways are skipped, and the
// emergency override holds back takeoffs. Grants leave via valid/ready.
//
// state | meaning
// IDLE  | no grant outstanding, looking for an eligible head and a free runway
// OFFER | grant_* registered and offered, waiting for grant_ready
module runway_scheduler #(
    parameter int ID_WIDTH    = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ID_WIDTH-1:0]              req_id,
    input  logic                             req_landing,
    input  logic                             rel_valid,
    input  logic                             rel_runway,
    input  logic [1:0]                       runway_override,
    input  logic                             emergency_override,
    output logic                             grant_valid,
    input  logic                             grant_ready,
    output logic [ID_WIDTH-1:0]              grant_id,
    output logic                             grant_runway,
    output logic                             grant_landing,
    output logic [1:0]                       runway_active,
    output logic                             emergency,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] land_count,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] takeoff_count
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

    typedef enum logic {IDLE, OFFER} state_t;
    state_t state, state_next;

    logic [ID_WIDTH-1:0] land_mem [QUEUE_DEPTH];
    logic [ID_WIDTH-1:0] take_mem [QUEUE_DEPTH];
    logic [PW-1:0] land_wr, land_rd, take_wr, take_rd;

    logic       land_push, take_push, land_pop, take_pop;
    logic       handshake, start;
    logic       land_elig, take_elig;
    logic [1:0] free;
    logic       sel_runway;

    assign req_ready = req_landing ? (land_count != FULL) : (takeoff_count != FULL);
    assign land_push = req_valid & req_ready & req_landing;
    assign take_push = req_valid & req_ready & ~req_landing;

    assign handshake = grant_valid & grant_ready;
    assign land_pop  = handshake & grant_landing;
    assign take_pop  = handshake & ~grant_landing;

    assign free       = ~runway_active & ~runway_override;
    assign sel_runway = free[0] ? 1'b0 : 1'b1;
    assign land_elig  = (land_count != '0);
    assign take_elig  = (land_count == '0) & ~emergency_override & (takeoff_count != '0);
    assign start      = (state == IDLE) & (|free) & (land_elig | take_elig);

    // Queue storage; entries need no reset because the pointers and counts define validity.
    always_ff @(posedge clock) begin
        if (land_push) land_mem[land_wr] <= req_id;
        if (take_push) take_mem[take_wr] <= req_id;
    end

    // Queue pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            land_wr       <= '0;
            land_rd       <= '0;
            take_wr       <= '0;
            take_rd       <= '0;
            land_count    <= '0;
            takeoff_count <= '0;
        end else begin
            if (land_push) land_wr <= land_wr + PW'(1);
            if (land_pop)  land_rd <= land_rd + PW'(1);
            if (take_push) take_wr <= take_wr + PW'(1);
            if (take_pop)  take_rd <= take_rd + PW'(1);
            case ({land_push, land_pop})
                2'b10:   land_count <= land_count + CW'(1);
                2'b01:   land_count <= land_count - CW'(1);
                default: ;
            endcase
            case ({take_push, take_pop})
                2'b10:   takeoff_count <= takeoff_count + CW'(1);
                2'b01:   takeoff_count <= takeoff_count - CW'(1);
                default: ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // FSM next state: an offer, once made, leaves only through the handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)       state_next = OFFER;
            OFFER:   if (grant_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        grant_valid = (state == OFFER);
    end

    // Grant fields are captured only on IDLE->OFFER, so they stay frozen for the whole offer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_id      <= '0;
            grant_runway  <= 1'b0;
            grant_landing <= 1'b0;
        end else if (start) begin
            grant_id      <= land_elig ? land_mem[land_rd] : take_mem[take_rd];
            grant_runway  <= sel_runway;
            grant_landing <= land_elig;
        end
    end

    // Runway occupancy: a grant taking a runway overrides a release of that same runway.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            runway_active <= 2'b00;
        end else begin
            if (rel_valid && !(handshake && (grant_runway == rel_runway)))
                runway_active[rel_runway] <= 1'b0;
            if (handshake)
                runway_active[grant_runway] <= 1'b1;
        end
    end

    // Registered emergency indicator.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) emergency <= 1'b0;
        else          emergency <= emergency_override | (land_count == FULL);
    end

endmodule

// File: tb/tb_runway_scheduler.sv
// Bench for runway_scheduler: directed scenarios plus random traffic, all
// checked against a queue-level model of the tower's scheduling rules.
module tb_runway_scheduler;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req_valid, req_ready, req_landing;
    logic [3:0] req_id;
    logic       rel_valid, rel_runway;
    logic [1:0] runway_override;
    logic       emergency_override;
    logic       grant_valid, grant_ready, grant_runway, grant_landing;
    logic [3:0] grant_id;
    logic [1:0] runway_active;
    logic       emergency;
    logic [2:0] land_count, takeoff_count;

    int total = 0;
    int bad   = 0;

    runway_scheduler #(.ID_WIDTH(4), .QUEUE_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_landing(req_landing),
        .rel_valid(rel_valid), .rel_runway(rel_runway),
        .runway_override(runway_override), .emergency_override(emergency_override),
        .grant_valid(grant_valid), .grant_ready(grant_ready), .grant_id(grant_id),
        .grant_runway(grant_runway), .grant_landing(grant_landing),
        .runway_active(runway_active), .emergency(emergency),
        .land_count(land_count), .takeoff_count(takeoff_count)
    );

    always #5 clock = ~clock;

    // Reference model: request queues, runway occupancy and the outstanding offer.
    logic [3:0] mq_l[$];
    logic [3:0] mq_t[$];
    bit         m_offer;
    logic [3:0] m_gid;
    logic       m_grw, m_gland, m_emg;
    logic [1:0] m_act;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        mq_l.delete();
        mq_t.delete();
        m_offer = 0;
        m_gid   = '0;
        m_grw   = 1'b0;
        m_gland = 1'b0;
        m_act   = 2'b00;
        m_emg   = 1'b0;
    endtask

    task automatic check_all();
        chk("grant_valid",   grant_valid,   m_offer);
        chk("grant_id",      grant_id,      m_gid);
        chk("grant_runway",  grant_runway,  m_grw);
        chk("grant_landing", grant_landing, m_gland);
        chk("runway_active", runway_active, m_act);
        chk("land_count",    land_count,    mq_l.size());
        chk("takeoff_count", takeoff_count, mq_t.size());
        chk("emergency",     emergency,     m_emg);
    endtask

    // One clock cycle: drive inputs after the falling edge, predict, compare after the rising edge.
    task automatic cyc(input logic rv, input logic rl, input logic [3:0] rid,
                       input logic relv, input logic relr, input logic [1:0] ovr,
                       input logic eo, input logic gr);
        logic       exp_ready, hs, push, le, te, start, new_emg;
        logic [1:0] fr, nact;
        req_valid = rv; req_landing = rl; req_id = rid;
        rel_valid = relv; rel_runway = relr;
        runway_override = ovr; emergency_override = eo; grant_ready = gr;
        #1;
        exp_ready = rl ? (mq_l.size() < DEPTH) : (mq_t.size() < DEPTH);
        chk("req_ready", req_ready, exp_ready);
        @(posedge clock);
        hs      = m_offer && gr;
        push    = rv && exp_ready;
        fr      = ~m_act & ~ovr;
        le      = mq_l.size() > 0;
        te      = (mq_l.size() == 0) && !eo && (mq_t.size() > 0);
        start   = !m_offer && (fr != 2'b00) && (le || te);
        new_emg = eo || (mq_l.size() == DEPTH);
        nact    = m_act;
        if (relv && !(hs && m_grw == relr)) nact[relr] = 1'b0;
        if (hs) nact[m_grw] = 1'b1;
        if (hs) begin
            if (m_gland) void'(mq_l.pop_front());
            else         void'(mq_t.pop_front());
        end
        if (start) begin
            m_gland = le;
            m_gid   = le ? mq_l[0] : mq_t[0];
            m_grw   = fr[0] ? 1'b0 : 1'b1;
        end
        if (push) begin
            if (rl) mq_l.push_back(rid);
            else    mq_t.push_back(rid);
        end
        if (hs)         m_offer = 0;
        else if (start) m_offer = 1;
        m_act = nact;
        m_emg = new_emg;
        #1;
        check_all();
        @(negedge clock);
    endtask

    task automatic idle(input logic [1:0] ovr, input logic eo, input logic gr);
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, ovr, eo, gr);
    endtask

    task automatic rel(input logic r);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, r, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 0; req_landing = 0; req_id = '0; rel_valid = 0; rel_runway = 0;
        runway_override = 2'b00; emergency_override = 0; grant_ready = 0;
        m_reset();
        repeat (2) @(negedge clock);
        check_all();
        reset_n = 1'b1;

        // Landing beats takeoff; second grant lands on the remaining runway.
        cyc(1, 1, 4'd3, 0, 0, 2'b00, 0, 0);
        cyc(1, 0, 4'd5, 0, 0, 2'b00, 0, 0);
        chk("first_id", grant_id, 4'd3);
        chk("first_rw", grant_runway, 1'b0);
        chk("first_land", grant_landing, 1'b1);
        idle(2'b00, 0, 1);
        idle(2'b00, 0, 0);
        chk("second_id", grant_id, 4'd5);
        chk("second_rw", grant_runway, 1'b1);
        idle(2'b00, 0, 1);
        chk("both_active", runway_active, 2'b11);
        rel(0);
        rel(1);

        // Closed runways are skipped; a fully closed field grants nothing.
        cyc(1, 0, 4'd7, 0, 0, 2'b01, 0, 0);
        idle(2'b01, 0, 0);
        chk("ovr01_rw", grant_runway, 1'b1);
        idle(2'b01, 0, 1);
        cyc(0, 0, 4'd0, 1, 1, 2'b01, 0, 0);
        cyc(1, 0, 4'd8, 0, 0, 2'b11, 0, 0);
        for (int i = 0; i < 3; i++) begin
            idle(2'b11, 0, 0);
            chk("closed_no_grant", grant_valid, 1'b0);
        end
        idle(2'b10, 0, 0);
        chk("reopen_rw", grant_runway, 1'b0);
        chk("reopen_id", grant_id, 4'd8);
        idle(2'b10, 0, 1);
        rel(0);

        // Emergency holds takeoffs back while landings still flow.
        cyc(1, 0, 4'd1, 0, 0, 2'b00, 1, 0);
        cyc(1, 0, 4'd2, 0, 0, 2'b00, 1, 0);
        chk("emg_set", emergency, 1'b1);
        cyc(1, 1, 4'd9, 0, 0, 2'b00, 1, 0);
        idle(2'b00, 1, 0);
        chk("emg_land_id", grant_id, 4'd9);
        for (int i = 0; i < 4; i++) idle(2'b00, 1, 1);
        chk("emg_take_held", takeoff_count, 3'd2);
        chk("emg_no_grant", grant_valid, 1'b0);
        for (int i = 0; i < 4; i++) idle(2'b00, 0, 1);
        rel(0);
        rel(1);
        for (int i = 0; i < 4; i++) idle(2'b00, 0, 1);
        rel(0);
        rel(1);
        chk("emg_drained", takeoff_count, 3'd0);

        // Full landing queue with the field closed.
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, 4'(10 + i), 0, 0, 2'b11, 0, 0);
        idle(2'b11, 0, 0);
        req_landing = 1'b1; #1;
        chk("full_ready_land", req_ready, 1'b0);
        req_landing = 1'b0; #1;
        chk("full_ready_take", req_ready, 1'b1);
        chk("full_count", land_count, 3'd4);
        chk("full_emg", emergency, 1'b1);
        @(negedge clock);
        for (int i = 0; i < 24; i++) cyc(0, 0, 4'd0, 1, 1'(i), 2'b00, 0, 1);
        idle(2'b00, 0, 1);
        rel(0);
        rel(1);

        // Held offer stays frozen; release in the handshake cycle loses to the set.
        cyc(1, 1, 4'd6, 0, 0, 2'b00, 0, 0);
        idle(2'b00, 0, 0);
        for (int i = 0; i < 5; i++) begin
            idle(2'(i + 1), 0, 0);
            chk("hold_valid", grant_valid, 1'b1);
            chk("hold_id", grant_id, 4'd6);
            chk("hold_rw", grant_runway, 1'b0);
        end
        cyc(0, 0, 4'd0, 1, 0, 2'b00, 0, 1);
        chk("set_wins", runway_active[0], 1'b1);
        rel(0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of an offer with entries queued.
        for (int i = 0; i < 8; i++) idle(2'b00, 0, 1);
        rel(0);
        rel(1);
        cyc(1, 1, 4'd1, 0, 0, 2'b00, 0, 0);
        idle(2'b00, 0, 0);
        idle(2'b00, 0, 1);
        cyc(1, 1, 4'd2, 0, 0, 2'b00, 0, 0);
        cyc(1, 1, 4'd3, 0, 0, 2'b00, 0, 0);
        cyc(1, 0, 4'd4, 0, 0, 2'b00, 0, 0);
        chk("pre_reset_offer", grant_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        m_reset();
        #1;
        chk("rst_valid", grant_valid, 1'b0);
        chk("rst_active", runway_active, 2'b00);
        chk("rst_land", land_count, 3'd0);
        chk("rst_take", takeoff_count, 3'd0);
        check_all();
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) idle(2'b00, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
